// File: rtl/blvds_pkg.sv
// Shared BLVDS framing definitions: bus bit positions, default
// marker words and the frame FSM state set (transmitter and receiver).
package blvds_pkg;

  localparam int FM_BIT = 17;
  localparam int DV_BIT = 16;

  localparam logic [15:0] HEAD_WORD_DEF   = 16'hAA55;
  localparam logic [15:0] EPILOG_WORD_DEF = 16'h55AA;
  localparam logic [17:0] BUS_IDLE        = 18'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_HEAD,
    ST_DATA,
    ST_CSUM,
    ST_EPILOG,
    ST_GAP
  } blvdsState_t;

  // Assemble an 18-bit bus word from marker, valid and payload
  function automatic logic [17:0] busWord(
    input logic        fm,
    input logic        dv,
    input logic [15:0] payload
  );
    logic [17:0] w;
    w         = BUS_IDLE;
    w[FM_BIT] = fm;
    w[DV_BIT] = dv;
    w[15:0]   = payload;
    return w;
  endfunction

endpackage

// File: rtl/blvds_checksum.sv
// 16-bit modular sum of frame data words.
// Only built when CHECKSUM_BLVDS_EN is defined.
`ifdef CHECKSUM_BLVDS_EN
module blvds_checksum (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        clear,
  input  logic        addEn,
  input  logic [15:0] data,
  output logic [15:0] sum
);

  // Running sum, restarted at the beginning of every frame
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (addEn) begin
      sum <= sum + data;
    end
  end

endmodule
`endif

// File: rtl/blvds_frame_transmitter.sv
// BLVDS frame transmitter: header, FIFO data, epilog, idle gap.
// Optional checksum word enabled by defining CHECKSUM_BLVDS_EN.
module blvds_frame_transmitter
  import blvds_pkg::*;
#(
  parameter logic [8:0]  FRAME_LEN   = 9'd256,
  parameter logic [15:0] HEAD_WORD   = HEAD_WORD_DEF,
  parameter logic [15:0] EPILOG_WORD = EPILOG_WORD_DEF,
  parameter logic [7:0]  FRAME_DELAY = 8'd100
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iENA,
  input  logic        iRD_EMPTY,
  input  logic [8:0]  iRDUSEDW,
  input  logic [15:0] iFIFO_DATA,
  output logic        oRD_REQ,
  output logic [17:0] oDATA_BLVDS,
  output logic        oBUSY,
  output logic        oSEND_OK,
  output logic [15:0] oFRAME_CNT
);

  blvdsState_t state;
  logic [8:0]  reqCnt;
  logic [8:0]  wordCnt;
  logic [7:0]  gapCnt;
  logic        lastWord;
  logic        startOk;

  assign lastWord = (wordCnt == FRAME_LEN - 9'd1);
  assign startOk  = iENA && !iRD_EMPTY &&
                    (iRDUSEDW >= FRAME_LEN);

`ifdef CHECKSUM_BLVDS_EN
  logic        sumClr;
  logic        sumAdd;
  logic [15:0] sum;

  assign sumClr = (state == ST_PREP);
  assign sumAdd = (state == ST_HEAD) ||
                  ((state == ST_DATA) && !lastWord);

  blvds_checksum uSum (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .clear (sumClr),
    .addEn (sumAdd),
    .data  (iFIFO_DATA),
    .sum   (sum)
  );
`endif

  // Read request: word 0 in PREP, then one per cycle until FRAME_LEN issued
  always_comb begin
    oRD_REQ = 1'b0;
    unique case (state)
      ST_PREP: oRD_REQ = 1'b1;
      ST_HEAD,
      ST_DATA: oRD_REQ = (reqCnt < FRAME_LEN);
      default: oRD_REQ = 1'b0;
    endcase
  end

  // Frame sequencer with registered bus, busy, pulse and frame counter
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= ST_IDLE;
      oDATA_BLVDS <= BUS_IDLE;
      oBUSY       <= 1'b0;
      oSEND_OK    <= 1'b0;
      oFRAME_CNT  <= '0;
      reqCnt      <= '0;
      wordCnt     <= '0;
      gapCnt      <= '0;
    end else begin
      oSEND_OK <= 1'b0;
      if (oRD_REQ) begin
        reqCnt <= (state == ST_PREP) ? 9'd1 : reqCnt + 9'd1;
      end
      unique case (state)
        ST_IDLE: begin
          oDATA_BLVDS <= BUS_IDLE;
          if (startOk) begin
            state <= ST_PREP;
            oBUSY <= 1'b1;
          end
        end
        ST_PREP: begin
          state       <= ST_HEAD;
          oDATA_BLVDS <= busWord(1'b1, 1'b1, HEAD_WORD);
        end
        ST_HEAD: begin
          state       <= ST_DATA;
          wordCnt     <= '0;
          oDATA_BLVDS <= busWord(1'b0, 1'b1, iFIFO_DATA);
        end
        ST_DATA: begin
          if (!lastWord) begin
            wordCnt     <= wordCnt + 9'd1;
            oDATA_BLVDS <= busWord(1'b0, 1'b1, iFIFO_DATA);
          end else begin
`ifdef CHECKSUM_BLVDS_EN
            state       <= ST_CSUM;
            oDATA_BLVDS <= busWord(1'b0, 1'b1, sum);
`else
            state       <= ST_EPILOG;
            oDATA_BLVDS <= busWord(1'b1, 1'b1, EPILOG_WORD);
            oSEND_OK    <= 1'b1;
            oFRAME_CNT  <= oFRAME_CNT + 16'd1;
`endif
          end
        end
`ifdef CHECKSUM_BLVDS_EN
        ST_CSUM: begin
          state       <= ST_EPILOG;
          oDATA_BLVDS <= busWord(1'b1, 1'b1, EPILOG_WORD);
          oSEND_OK    <= 1'b1;
          oFRAME_CNT  <= oFRAME_CNT + 16'd1;
        end
`endif
        ST_EPILOG: begin
          oDATA_BLVDS <= BUS_IDLE;
          gapCnt      <= '0;
          if (FRAME_DELAY == 8'd0) begin
            state <= ST_IDLE;
            oBUSY <= 1'b0;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          oDATA_BLVDS <= BUS_IDLE;
          if (gapCnt == FRAME_DELAY - 8'd1) begin
            state <= ST_IDLE;
            oBUSY <= 1'b0;
          end else begin
            gapCnt <= gapCnt + 8'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          oBUSY       <= 1'b0;
          oDATA_BLVDS <= BUS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/blvds_frame_transmitter.md
# blvds_frame_transmitter

Frame transmitter for the 18-bit BLVDS link; the transmit end of the framing that the BLVDS receiver checks. It drains 16-bit words from a single-clock read FIFO and drives header, FRAME_LEN data words, optional checksum and epilog onto the bus, followed by a configurable idle gap. Instantiated on the source board's 56 MHz domain, feeding the BLVDS output buffers directly.

## Interface
- FRAME_LEN, 9'd256, data words per frame; legal range 2..511
- HEAD_WORD, 16'hAA55, header payload
- EPILOG_WORD, 16'h55AA, epilog payload
- FRAME_DELAY, 8'd100, idle cycles between frames; 0 means no gap
- iCLK  in  1  system clock, all logic rising-edge
- iRST  in  1  reset, asynchronous, active-low
- iENA  in  1  transmit enable, sampled only in IDLE
- iRD_EMPTY  in  1  FIFO empty flag
- iRDUSEDW  in  9  FIFO fill level
- iFIFO_DATA  in  16  FIFO q, valid one cycle after oRD_REQ
- oRD_REQ  out  1  FIFO read request, combinational from state/counter
- oDATA_BLVDS  out  18  bus word: [17] frame marker FM, [16] data valid DV, [15:0] payload
- oBUSY  out  1  high from PREP through last GAP cycle
- oSEND_OK  out  1  one-cycle pulse, coincident with epilog on bus
- oFRAME_CNT  out  16  frames completed, wraps 16'hFFFF -> 0

## Operation
- States: IDLE, PREP, HEAD, DATA, (CSUM), EPILOG, GAP.
- IDLE: bus 18'h0. Leave to PREP when iENA=1, iRD_EMPTY=0, iRDUSEDW >= FRAME_LEN.
- PREP (1 cycle): oRD_REQ=1 (word 0); bus idle; clear checksum, request counter.
- HEAD (1 cycle): bus {2'b11, HEAD_WORD}; oRD_REQ=1 (word 1).
- DATA (FRAME_LEN cycles): bus {2'b01, iFIFO_DATA} registered; oRD_REQ=1 while requests issued < FRAME_LEN; exactly FRAME_LEN requests per frame total.
- CSUM (CHECKSUM_BLVDS_EN only, 1 cycle): bus {2'b01, sum}.
- EPILOG (1 cycle): bus {2'b11, EPILOG_WORD}; oSEND_OK=1; oFRAME_CNT increments.
- GAP: bus 18'h0 for FRAME_DELAY cycles, then IDLE; skipped when FRAME_DELAY=0.
- iENA falling mid-frame: frame completes normally, no new frame started.
- iRD_EMPTY during DATA cannot occur under the start condition; not handled further.

## Timing
- Reset values: oDATA_BLVDS=0, oRD_REQ=0, oBUSY=0, oSEND_OK=0, oFRAME_CNT=0, state IDLE, counters 0.
- Reset mid-frame: bus to 0 asynchronously; partial frame abandoned; FIFO words already read are lost.
- Start condition true at edge N: PREP in cycle N+1, header on bus after edge N+2, word 0 after edge N+3.
- Bus frame length: FRAME_LEN+2 cycles (+1 with checksum); DV continuous, no holes.
- Frame period in steady state: 1 + FRAME_LEN+2(+1) + FRAME_DELAY + 1 (IDLE) cycles.
- All bus outputs registered; oRD_REQ is the only combinational output.

## Configuration
- CHECKSUM_BLVDS_EN defined: CSUM state inserted; payload = 16-bit sum modulo 2^16 of all FRAME_LEN data words; the matching receiver build checks it.
- Not defined: no CSUM state, no accumulator; epilog follows last data word directly.

## Structure
- Package blvds_pkg: FM/DV bit indices, default HEAD_WORD/EPILOG_WORD, IDLE bus word, state enum; shared with the receiver.
- Optional sub-module blvds_checksum (clear, add-enable, 16-bit sum) instantiated only under CHECKSUM_BLVDS_EN.

## Test plan
- FRAME_LEN=4, FRAME_DELAY=2, FIFO preloaded 1,2,3,4, iENA=1 -> bus 3_AA55, 1_0001..1_0004, 3_55AA, then 0 for 2 cycles; oSEND_OK one pulse; oFRAME_CNT=1; exactly 4 oRD_REQ cycles.
- iRDUSEDW=3 with FRAME_LEN=4 -> stays IDLE, oRD_REQ never high; raise to 4 -> PREP next cycle.
- CHECKSUM_BLVDS_EN, words FFFF,0002,0003,0004 -> CSUM word 1_0008 before epilog.
- Continuous full FIFO, FRAME_DELAY=0, 3 frames -> periods of FRAME_LEN+4 cycles, oFRAME_CNT=3, data order preserved.
- iRST low during DATA word 2 -> bus 0 immediately; after release with refilled FIFO, next frame starts with header.
- Preload oFRAME_CNT to 16'hFFFF (force), send frame -> wraps to 0.
